// File: rtl/barrel_shift_pipe_pkg.sv
// -----------------------------------------------------------------------------
// barrel_shift_pipe_pkg
// Shared constants and operation encodings for the pipelined barrel shifter.
//   W      : data width (only 8 is supported)
//   SHW    : shift-amount width, log2(W)
//   OP_*   : operation codes carried alongside each entry through the pipe
// -----------------------------------------------------------------------------
package barrel_shift_pipe_pkg;

   localparam int W   = 8;
   localparam int SHW = 3;

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,   // logical left, zero fill
      OP_SRL = 2'b01,   // logical right, zero fill
      OP_SRA = 2'b10,   // arithmetic right, fill with original bit 7
      OP_ROR = 2'b11    // rotate right
   } shift_op_e;

endpackage : barrel_shift_pipe_pkg

// File: rtl/barrel_shift_pipe_shift_stage.sv
// -----------------------------------------------------------------------------
// shift_stage
// One register stage of the barrel shifter. Conditionally shifts the incoming
// operand by DIST positions (DIST = 1, 2 or 4) when the shift-amount bit that
// belongs to this stage is set, and registers the result together with its
// valid bit, op code and shift amount for the next stage.
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   up_valid_i    : upstream entry present
//   up_ready_o    : this stage can take the upstream entry this cycle
//   up_data_i     : operand from upstream
//   up_shamt_i    : shift amount travelling with the entry
//   up_op_i       : operation travelling with the entry
//   dn_valid_o    : this stage holds an entry
//   dn_ready_i    : downstream takes the held entry this cycle
//   dn_data_o     : registered (partially) shifted operand
//   dn_shamt_o    : registered shift amount
//   dn_op_o       : registered operation
// -----------------------------------------------------------------------------
module shift_stage
   import barrel_shift_pipe_pkg::*;
#(
   parameter int DIST = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           up_valid_i,
   output logic           up_ready_o,
   input  logic [W-1:0]   up_data_i,
   input  logic [SHW-1:0] up_shamt_i,
   input  logic [1:0]     up_op_i,
   output logic           dn_valid_o,
   input  logic           dn_ready_i,
   output logic [W-1:0]   dn_data_o,
   output logic [SHW-1:0] dn_shamt_o,
   output logic [1:0]     dn_op_o
);

   // Shift-amount bit controlling this stage: 1 -> bit 0, 2 -> bit 1, 4 -> bit 2.
   localparam int SEL = $clog2(DIST);

   logic           valid_q, valid_d;
   logic [W-1:0]   data_q,  data_d;
   logic [SHW-1:0] shamt_q, shamt_d;
   logic [1:0]     op_q,    op_d;

   logic           sel_bit;
   logic           load;
   logic [W-1:0]   shifted;

   assign sel_bit = up_shamt_i[SEL];

   // -------------------------------------------------------------------------
   // Per-bit 4:1 selection. Each output bit picks one of four candidates by
   // op when this stage's shift bit is set, otherwise passes through. The
   // candidate wiring is fixed at elaboration, so out-of-range source bits
   // become the proper fill value instead of a run-time comparison.
   // -------------------------------------------------------------------------
   for (genvar gi = 0; gi < W; gi++) begin : g_bit
      logic sll_b, srl_b, sra_b, ror_b, out_b;

      if (gi >= DIST) begin : g_sll_src
         assign sll_b = up_data_i[gi-DIST];
      end else begin : g_sll_fill
         assign sll_b = 1'b0;
      end

      if (gi + DIST < W) begin : g_sr_src
         assign srl_b = up_data_i[gi+DIST];
         assign sra_b = up_data_i[gi+DIST];
      end else begin : g_sr_fill
         // Sign bit is never changed by earlier stages on an SRA, so the
         // current bit 7 is still the original bit 7.
         assign srl_b = 1'b0;
         assign sra_b = up_data_i[W-1];
      end

      assign ror_b = up_data_i[(gi+DIST)%W];

      always_comb begin
         out_b = up_data_i[gi];
         case ({sel_bit, up_op_i})
            {1'b1, OP_SLL}: out_b = sll_b;
            {1'b1, OP_SRL}: out_b = srl_b;
            {1'b1, OP_SRA}: out_b = sra_b;
            {1'b1, OP_ROR}: out_b = ror_b;
            default:        out_b = up_data_i[gi];
         endcase
      end

      assign shifted[gi] = out_b;
   end

   // -------------------------------------------------------------------------
   // Handshake: the stage accepts when empty or when its entry leaves in the
   // same cycle, which collapses bubbles and sustains one entry per cycle.
   // -------------------------------------------------------------------------
   assign up_ready_o = !valid_q || dn_ready_i;
   assign load       = up_valid_i && up_ready_o;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      shamt_d = shamt_q;
      op_d    = op_q;
      if (up_ready_o) begin
         valid_d = up_valid_i;
      end
      // Payload only moves with a real transfer so the output data stays at
      // its last value (0 after reset) when no entry arrives.
      if (load) begin
         data_d  = shifted;
         shamt_d = up_shamt_i;
         op_d    = up_op_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         shamt_q <= '0;
         op_q    <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         shamt_q <= shamt_d;
         op_q    <= op_d;
      end
   end

   assign dn_valid_o = valid_q;
   assign dn_data_o  = data_q;
   assign dn_shamt_o = shamt_q;
   assign dn_op_o    = op_q;

endmodule : shift_stage

// File: rtl/barrel_shift_pipe.sv
// -----------------------------------------------------------------------------
// barrel_shift_pipe
// Three-stage pipelined 8-bit barrel shifter with valid/ready handshakes on
// both sides. Stage k shifts by 2^k when shift-amount bit k is set.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset, discards all entries
//   in_valid   : command presented
//   in_ready   : command accepted this cycle (independent of in_valid)
//   in_data    : operand
//   in_shamt   : shift amount 0..7
//   in_op      : 00 SLL, 01 SRL, 10 SRA, 11 ROR
//   out_valid  : result presented
//   out_ready  : consumer accepts result
//   out_data   : result, held while out_valid && !out_ready
//   busy       : any stage holds an entry
// -----------------------------------------------------------------------------
module barrel_shift_pipe
   import barrel_shift_pipe_pkg::SHW;
#(
   parameter int W = 8   // only 8 is supported
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_data,
   input  logic [SHW-1:0] in_shamt,
   input  logic [1:0]     in_op,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   out_data,
   output logic           busy
);

   // Index 0 is the input port, index k (1..3) is the output of stage k.
   logic           valid_a [0:3];
   logic           ready_a [0:3];
   logic [W-1:0]   data_a  [0:3];
   logic [SHW-1:0] shamt_a [0:3];
   logic [1:0]     op_a    [0:3];

   assign valid_a[0] = in_valid;
   assign data_a[0]  = in_data;
   assign shamt_a[0] = in_shamt;
   assign op_a[0]    = in_op;
   assign in_ready   = ready_a[0];
   assign ready_a[3] = out_ready;

   for (genvar gi = 0; gi < 3; gi++) begin : g_stage
      shift_stage #(
         .DIST (1 << gi)
      ) u_stage (
         .clk        (clk),
         .rst        (rst),
         .up_valid_i (valid_a[gi]),
         .up_ready_o (ready_a[gi]),
         .up_data_i  (data_a[gi]),
         .up_shamt_i (shamt_a[gi]),
         .up_op_i    (op_a[gi]),
         .dn_valid_o (valid_a[gi+1]),
         .dn_ready_i (ready_a[gi+1]),
         .dn_data_o  (data_a[gi+1]),
         .dn_shamt_o (shamt_a[gi+1]),
         .dn_op_o    (op_a[gi+1])
      );
   end

   assign out_valid = valid_a[3];
   assign out_data  = data_a[3];
   assign busy      = valid_a[1] || valid_a[2] || valid_a[3];

endmodule : barrel_shift_pipe
